// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: sequences each instruction
// through fetch/decode/execute/memory/writeback and counts retired instructions.
//
// state    | meaning
// FETCH    | IR <- mem[PC], PC <- PC+4
// DECODE   | ALUOut <- OldPC+imm, dispatch on opcode
// MEMADR   | ALUOut <- rs1+imm (load/store address)
// MEMREAD  | MDR <- mem[ALUOut]
// MEMWB    | rd <- MDR
// MEMWRITE | mem[ALUOut] <- rs2
// EXECR    | ALUOut <- rs1 op rs2
// EXECI    | ALUOut <- rs1 op imm
// ALUWB    | rd <- ALUOut
// BRANCH   | compare rs1/rs2, PC <- ALUOut if taken
// JALR     | ALUOut <- rs1+imm
// JAL      | PC <- ALUOut, ALUOut <- OldPC+4
// LUI      | rd <- imm
module multicycle_controller #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic [2:0]       func3,
   input  logic             zero,
   input  logic             neg,
   output logic             PCWrite,
   output logic             AdrSrc,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegWrite,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [2:0]       ImmSrc,
   output logic [1:0]       ALUOp,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
      S_EXECI, S_ALUWB, S_BRANCH, S_JALR, S_JAL, S_LUI
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pcw, memw, irw, regw, ill, taken;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:              state_d = S_EXECR;
               OP_I:              state_d = S_EXECI;
               OP_BR:             state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_LUI:            state_d = S_LUI;
               default:           state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECR,
         S_EXECI,
         S_JAL:      state_d = S_ALUWB;
         S_JALR:     state_d = S_JAL;
         default:    state_d = S_FETCH;
      endcase
      // DECODE->FETCH is only the illegal path, which does not retire
      cnt_d = cnt_q;
      if (state_d == S_FETCH && state_q != S_DECODE) cnt_d = cnt_q + CNT_W'(1);
   end

   always_comb begin
      case (func3)
         3'b000:  taken = zero;
         3'b001:  taken = !zero;
         3'b100:  taken = neg;
         3'b101:  taken = !neg;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      pcw = 1'b0; AdrSrc = 1'b0; memw = 1'b0; irw = 1'b0; regw = 1'b0; ill = 1'b0;
      ResultSrc = 2'd0; ALUSrcA = 2'd0; ALUSrcB = 2'd0; ALUOp = 2'd0;
      case (state_q)
         S_FETCH:    begin irw = 1'b1; pcw = 1'b1; ALUSrcB = 2'd2; ResultSrc = 2'd2; end
         S_DECODE: begin
            ALUSrcA = 2'd1; ALUSrcB = 2'd1;
            case (opcode)
               OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI: ill = 1'b0;
               default: ill = 1'b1;
            endcase
         end
         S_MEMADR:   begin ALUSrcA = 2'd2; ALUSrcB = 2'd1; end
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWB:    begin ResultSrc = 2'd1; regw = 1'b1; end
         S_MEMWRITE: begin AdrSrc = 1'b1; memw = 1'b1; end
         S_EXECR:    begin ALUSrcA = 2'd2; ALUOp = 2'd2; end
         S_EXECI:    begin ALUSrcA = 2'd2; ALUSrcB = 2'd1; ALUOp = 2'd3; end
         S_ALUWB:    regw = 1'b1;
         S_BRANCH:   begin ALUSrcA = 2'd2; ALUOp = 2'd1; pcw = taken; end
         S_JALR:     begin ALUSrcA = 2'd2; ALUSrcB = 2'd1; end
         S_JAL:      begin pcw = 1'b1; ALUSrcA = 2'd1; ALUSrcB = 2'd2; end
         S_LUI:      begin ResultSrc = 2'd3; regw = 1'b1; end
         default:    ;
      endcase
   end

   always_comb begin
      case (opcode)
         OP_LOAD, OP_I, OP_JALR: ImmSrc = 3'd0;
         OP_STORE:               ImmSrc = 3'd1;
         OP_BR:                  ImmSrc = 3'd2;
         OP_JAL:                 ImmSrc = 3'd3;
         OP_LUI:                 ImmSrc = 3'd4;
         default:                ImmSrc = 3'd0;
      endcase
   end

   // write enables are killed while reset is held so an abandoned instruction writes nothing
   assign PCWrite   = pcw  & rst;
   assign MemWrite  = memw & rst;
   assign IRWrite   = irw  & rst;
   assign RegWrite  = regw & rst;
   assign illegal   = ill  & rst;
   assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through
// its state path and compares every output cycle by cycle against hand-built vectors.
module tb_multicycle_controller;

   localparam int CNT_W = 4;

   localparam int FE = 0, DE = 1, MA = 2, MR = 3, MWB = 4, MW = 5, ER = 6,
                  EI = 7, AWB = 8, BR = 9, JR = 10, JL = 11, LU = 12;

   logic             clk = 1'b0;
   logic             rst;
   logic [6:0]       opcode;
   logic [2:0]       func3;
   logic             zero, neg;
   logic             PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
   logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
   logic [2:0]       ImmSrc;
   logic [CNT_W-1:0] instr_cnt;
   logic [16:0]      outs;

   int checks = 0;
   int errors = 0;

   multicycle_controller #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .zero(zero), .neg(neg),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .ALUOp(ALUOp), .illegal(illegal), .instr_cnt(instr_cnt)
   );

   always #5 clk = ~clk;

   assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, ALUOp, illegal};

   // Expected output vector for a state, hand-tabulated from the state table
   function automatic logic [16:0] exp_vec(int st, logic [6:0] opc, logic br, logic r);
      logic pcw, adr, mw, irw, rw, ill;
      logic [1:0] rs, a, b, op;
      logic [2:0] imm;
      {pcw, adr, mw, irw, rw, ill} = 6'b0;
      rs = 2'd0; a = 2'd0; b = 2'd0; op = 2'd0;
      case (st)
         FE:  begin irw = 1; pcw = 1; b = 2; rs = 2; end
         DE:  begin a = 1; b = 1;
                    ill = !(opc inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                        7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111}); end
         MA:  begin a = 2; b = 1; end
         MR:  adr = 1;
         MWB: begin rs = 1; rw = 1; end
         MW:  begin adr = 1; mw = 1; end
         ER:  begin a = 2; op = 2; end
         EI:  begin a = 2; b = 1; op = 3; end
         AWB: rw = 1;
         BR:  begin a = 2; op = 1; pcw = br; end
         JR:  begin a = 2; b = 1; end
         JL:  begin pcw = 1; a = 1; b = 2; end
         LU:  begin rs = 3; rw = 1; end
         default: ;
      endcase
      case (opc)
         7'b0100011: imm = 3'd1;
         7'b1100011: imm = 3'd2;
         7'b1101111: imm = 3'd3;
         7'b0110111: imm = 3'd4;
         default:    imm = 3'd0;
      endcase
      if (!r) begin pcw = 0; mw = 0; irw = 0; rw = 0; ill = 0; end
      return {pcw, adr, mw, irw, rw, rs, a, b, imm, op, ill};
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b0; opcode = 7'd0; func3 = 3'd0; zero = 1'b0; neg = 1'b0;
      tick(); tick();
      #1;
      checks++;
      if (outs !== exp_vec(FE, opcode, 1'b0, 1'b0)) begin
         errors++; $display("FAIL reset_gated: got %h expected %h", outs, exp_vec(FE, opcode, 1'b0, 1'b0));
      end
      rst = 1'b1;
      #1;
      checks++;
      if (outs !== exp_vec(FE, opcode, 1'b0, 1'b1)) begin
         errors++; $display("FAIL reset_first_fetch: got %h expected %h", outs, exp_vec(FE, opcode, 1'b0, 1'b1));
      end
      checks++;
      if (instr_cnt !== 4'd0) begin
         errors++; $display("FAIL reset_cnt: got %0d expected 0", instr_cnt);
      end
   endtask

   task automatic test_mem_alu();
      logic [6:0] opcs [4] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011};
      int paths [4][5] = '{'{FE, DE, MA, MR, MWB}, '{FE, DE, MA, MW, 0},
                           '{FE, DE, ER, AWB, 0}, '{FE, DE, EI, AWB, 0}};
      int lens [4] = '{5, 4, 4, 4};
      for (int k = 0; k < 4; k++) begin
         opcode = opcs[k];
         for (int i = 0; i < lens[k]; i++) begin
            #1;
            checks++;
            if (outs !== exp_vec(paths[k][i], opcode, 1'b0, 1'b1)) begin
               errors++;
               $display("FAIL mem_alu op%0d cyc%0d: got %h expected %h", k, i, outs,
                        exp_vec(paths[k][i], opcode, 1'b0, 1'b1));
            end
            tick();
         end
      end
      #1;
      checks++;
      if (instr_cnt !== 4'd4) begin
         errors++; $display("FAIL mem_alu_cnt: got %0d expected 4", instr_cnt);
      end
   endtask

   task automatic test_branch();
      logic [2:0] f3s [4] = '{3'b000, 3'b001, 3'b100, 3'b101};
      logic       zs  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic       ns  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic       tk  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      int         path [3] = '{FE, DE, BR};
      opcode = 7'b1100011;
      for (int k = 0; k < 4; k++) begin
         func3 = f3s[k]; zero = zs[k]; neg = ns[k];
         for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs !== exp_vec(path[i], opcode, tk[k], 1'b1)) begin
               errors++;
               $display("FAIL branch%0d cyc%0d: got %h expected %h", k, i, outs,
                        exp_vec(path[i], opcode, tk[k], 1'b1));
            end
            tick();
         end
      end
      zero = 1'b0; neg = 1'b0; func3 = 3'd0;
      #1;
      checks++;
      if (instr_cnt !== 4'd8) begin
         errors++; $display("FAIL branch_cnt: got %0d expected 8", instr_cnt);
      end
   endtask

   task automatic test_jump_lui();
      logic [6:0] opcs [3] = '{7'b1100111, 7'b1101111, 7'b0110111};
      int paths [3][5] = '{'{FE, DE, JR, JL, AWB}, '{FE, DE, JL, AWB, 0}, '{FE, DE, LU, 0, 0}};
      int lens [3] = '{5, 4, 3};
      for (int k = 0; k < 3; k++) begin
         opcode = opcs[k];
         for (int i = 0; i < lens[k]; i++) begin
            #1;
            checks++;
            if (outs !== exp_vec(paths[k][i], opcode, 1'b0, 1'b1)) begin
               errors++;
               $display("FAIL jump_lui op%0d cyc%0d: got %h expected %h", k, i, outs,
                        exp_vec(paths[k][i], opcode, 1'b0, 1'b1));
            end
            tick();
         end
      end
      #1;
      checks++;
      if (instr_cnt !== 4'd11) begin
         errors++; $display("FAIL jump_lui_cnt: got %0d expected 11", instr_cnt);
      end
   endtask

   task automatic test_illegal();
      int path [3] = '{FE, DE, FE};
      opcode = 7'b1111111;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (outs !== exp_vec(path[i], opcode, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL illegal cyc%0d: got %h expected %h", i, outs,
                     exp_vec(path[i], opcode, 1'b0, 1'b1));
         end
         if (i < 2) tick();
      end
      checks++;
      if (instr_cnt !== 4'd11) begin
         errors++; $display("FAIL illegal_cnt: got %0d expected 11", instr_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int path [3] = '{FE, DE, MA};
      opcode = 7'b0100011;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (outs !== exp_vec(path[i], opcode, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL reset_mid cyc%0d: got %h expected %h", i, outs,
                     exp_vec(path[i], opcode, 1'b0, 1'b1));
         end
         tick();
      end
      rst = 1'b0;
      #1;
      checks++;
      if (outs !== exp_vec(MW, opcode, 1'b0, 1'b0) || MemWrite !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_memwrite: got %h expected %h", outs, exp_vec(MW, opcode, 1'b0, 1'b0));
      end
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if (outs !== exp_vec(FE, opcode, 1'b0, 1'b1)) begin
         errors++; $display("FAIL reset_mid_fetch: got %h expected %h", outs, exp_vec(FE, opcode, 1'b0, 1'b1));
      end
      checks++;
      if (instr_cnt !== 4'd0) begin
         errors++; $display("FAIL reset_mid_cnt: got %0d expected 0", instr_cnt);
      end
   endtask

   task automatic test_wrap();
      opcode = 7'b0110111;
      for (int k = 0; k < 15; k++) begin
         tick(); tick(); tick();
      end
      #1;
      checks++;
      if (instr_cnt !== 4'hF) begin
         errors++; $display("FAIL wrap_all_ones: got %0d expected 15", instr_cnt);
      end
      tick(); tick(); tick();
      #1;
      checks++;
      if (instr_cnt !== 4'd0) begin
         errors++; $display("FAIL wrap_zero: got %0d expected 0", instr_cnt);
      end
      checks++;
      if (outs !== exp_vec(FE, opcode, 1'b0, 1'b1)) begin
         errors++; $display("FAIL wrap_fetch: got %h expected %h", outs, exp_vec(FE, opcode, 1'b0, 1'b1));
      end
   endtask

   initial begin
      test_reset();
      test_mem_alu();
      test_branch();
      test_jump_lui();
      test_illegal();
      test_reset_mid();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
